// File: rtl/multi_cycle_control.sv
// ============================================================================
// Module      : multi_cycle_control
// Description : Main control FSM for a multi-cycle MIPS-style datapath.
//               Sequences fetch/decode/execute/memory/write-back steps,
//               bounds every memory wait with TIMEOUT cycles, and keeps
//               sticky Illegal (bad opcode) and Mem_err (timeout) flags.
// Options     : MULTI_CYCLE_CONTROL_JAL_EN - when defined, opcode 000011
//               (jal) is decoded to JUMP and links PC into $31.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       Mem_ready,
  output logic       PC_w,
  output logic       IorD,
  output logic       Mem_r,
  output logic       Mem_w,
  output logic       IR_w,
  output logic       Mem_to_reg,
  output logic       Reg_dst,
  output logic       Reg_w,
  output logic       ALU_src_A,
  output logic       Link,
  output logic [1:0] ALU_src_B,
  output logic [1:0] ALU_op,
  output logic [1:0] PC_src,
  output logic [3:0] State,
  output logic       Illegal,
  output logic       Mem_err
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_EXEC_I    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  // Last wait-count value before a memory access is declared dead.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [7:0] count;
  logic [5:0] op_latched;
  logic       illegal_q;
  logic       mem_err_q;
  logic       decode_bad;
  logic       ready;
  logic       wait_state;
  logic       timeout;

  // Reset masks Mem_ready so outputs show idle FETCH values while held in reset.
  assign ready      = Mem_ready & ~rst;
  assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) ||
                      (state == S_MEM_WRITE);
  assign timeout    = wait_state && !ready && (count == CNT_LAST);

  // Next-state selection; DECODE looks at the live opcode, later states at the latched copy.
  always_comb begin
    next_state = state;
    decode_bad = 1'b0;
    case (state)
      S_FETCH:     if (ready) next_state = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:         next_state = S_EXEC_R;
          OP_LW, OP_SW:     next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
          OP_JAL:           next_state = S_JUMP;
`endif
          OP_ADDIU, OP_ORI: next_state = S_EXEC_I;
          default: begin
            next_state = S_FETCH;
            decode_bad = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (op_latched == OP_SW) ? S_MEM_WRITE :
                                (op_latched == OP_LW) ? S_MEM_READ  : S_FETCH;
      S_MEM_READ:  if (ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (ready) next_state = S_FETCH;
      S_MEM_WB:    next_state = S_FETCH;
      S_EXEC_R:    next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_EXEC_I:    next_state = S_I_WB;
      S_I_WB:      next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      default:     next_state = S_FETCH;
    endcase
  end

  // State, wait counter, opcode latch and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      count      <= 8'd0;
      op_latched <= 6'd0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        op_latched <= OpCode;
        if (decode_bad) illegal_q <= 1'b1;
      end
      if (timeout) begin
        // Abandon the access; re-entering FETCH restarts the wait count.
        mem_err_q <= 1'b1;
        state     <= S_FETCH;
        count     <= 8'd0;
      end else begin
        state <= next_state;
        if (next_state != state)
          count <= 8'd0;
        else if (wait_state && !ready)
          count <= count + 8'd1;
      end
    end
  end

  // Datapath controls decoded from the current state; timeout drops memory strobes.
  always_comb begin
    PC_w       = 1'b0;
    IorD       = 1'b0;
    Mem_r      = 1'b0;
    Mem_w      = 1'b0;
    IR_w       = 1'b0;
    Mem_to_reg = 1'b0;
    Reg_dst    = 1'b0;
    Reg_w      = 1'b0;
    ALU_src_A  = 1'b0;
    Link       = 1'b0;
    ALU_src_B  = 2'b00;
    ALU_op     = 2'b00;
    PC_src     = 2'b00;
    case (state)
      S_FETCH: begin
        Mem_r     = ~timeout;
        ALU_src_B = 2'b01;
        if (ready) begin
          IR_w = 1'b1;
          PC_w = 1'b1;
        end
      end
      S_DECODE: ALU_src_B = 2'b11;
      S_MEM_ADDR: begin
        ALU_src_A = 1'b1;
        ALU_src_B = 2'b10;
      end
      S_MEM_READ: begin
        Mem_r = ~timeout;
        IorD  = 1'b1;
      end
      S_MEM_WRITE: begin
        Mem_w = ~timeout;
        IorD  = 1'b1;
      end
      S_MEM_WB: begin
        Reg_w      = 1'b1;
        Mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        ALU_src_A = 1'b1;
        ALU_op    = 2'b10;
      end
      S_R_WB: begin
        Reg_w   = 1'b1;
        Reg_dst = 1'b1;
      end
      S_EXEC_I: begin
        ALU_src_A = 1'b1;
        ALU_src_B = 2'b10;
        ALU_op    = (op_latched == OP_ORI) ? 2'b11 : 2'b00;
      end
      S_I_WB: Reg_w = 1'b1;
      S_BRANCH: begin
        ALU_src_A = 1'b1;
        ALU_op    = 2'b01;
        PC_src    = 2'b01;
        PC_w      = ((op_latched == OP_BEQ) &&  Zero) ||
                    ((op_latched == OP_BNE) && !Zero);
      end
      S_JUMP: begin
        PC_src = 2'b10;
        PC_w   = 1'b1;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
        if (op_latched == OP_JAL) begin
          Reg_w = 1'b1;
          Link  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign State   = state;
  assign Illegal = illegal_q;
  assign Mem_err = mem_err_q;

endmodule

`default_nettype wire
